// File: rtl/stim_pkg.sv
// Shared definitions for the audio stimulus generator: mode codes, FSM
// state encoding and the noise LFSR tap mask / step helper.
package stim_pkg;

   // Pattern selection codes as seen on the mode input
   localparam logic [2:0] STIM_ZERO    = 3'd0;
   localparam logic [2:0] STIM_STEP    = 3'd1;
   localparam logic [2:0] STIM_RAMP    = 3'd2;
   localparam logic [2:0] STIM_CONST   = 3'd3;
   localparam logic [2:0] STIM_NOISE   = 3'd4;
   localparam logic [2:0] STIM_IMPULSE = 3'd5;

   // Burst sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } stim_state_e;

   // Galois tap mask for the 32-bit right-shifting noise LFSR
   localparam logic [31:0] STIM_LFSR_TAPS = 32'h8020_0003;

   // One right-shift Galois step: feed the outgoing LSB back through the taps
   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ STIM_LFSR_TAPS) : (s >> 1);
   endfunction

endpackage

// File: rtl/stim_lfsr.sv
// 32-bit Galois noise LFSR with seed load and single-step enable.
// Load wins over step so a new burst always restarts from the seed.
module stim_lfsr
   import stim_pkg::*;
#(
   parameter logic [31:0] SEED = 32'hACE1_0001
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_i,
   input  logic        step_i,
   output logic [31:0] state_o
);

   logic [31:0] state_q;
   logic [31:0] state_d;

   // Next-state selection: reload seed, advance one step, or hold
   always_comb begin
      state_d = state_q;
      if (load_i) begin
         state_d = SEED;
      end else if (step_i) begin
         state_d = lfsr_step(state_q);
      end
   end

   // State register, returns to the seed on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SEED;
      end else begin
         state_q <= state_d;
      end
   end

   assign state_o = state_q;

endmodule

// File: rtl/audio_stim_gen.sv
// Audio test-pattern generator: emits a burst of num_samples samples
// (zero/step/ramp/const/noise/impulse) over a valid/ready handshake.
// All outputs are registered; the value for the next index is computed
// in the same cycle the current sample is accepted.
// Optional feature macro: STIM_LFSR_EN (NOISE mode). When undefined the
// LFSR is absent and mode 4 produces zeros with normal handshake timing.
module audio_stim_gen
   import stim_pkg::*;
#(
   parameter int unsigned DATA_W    = 24,
   parameter int unsigned LEN_W     = 16,
   parameter logic [31:0] LFSR_SEED = 32'hACE1_0001
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [2:0]        mode,
   input  logic [LEN_W-1:0]  num_samples,
   input  logic [LEN_W-1:0]  step_at,
   input  logic [DATA_W-1:0] level,
   input  logic [DATA_W-1:0] ramp_inc,
   output logic [DATA_W-1:0] sample_out,
   output logic              sample_valid,
   input  logic              sample_ready,
   output logic [LEN_W-1:0]  sample_idx,
   output logic              busy,
   output logic              done
);

   stim_state_e       state_q, state_d;
   logic [2:0]        mode_q, mode_d;
   logic [LEN_W-1:0]  num_q, num_d;
   logic [LEN_W-1:0]  step_at_q, step_at_d;
   logic [DATA_W-1:0] level_q, level_d;
   logic [DATA_W-1:0] inc_q, inc_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [LEN_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] out_q, out_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   // Deterministic pattern value for index i (noise handled separately)
   function automatic logic [DATA_W-1:0] sample_value(
      input logic [2:0]        m,
      input logic [LEN_W-1:0]  i,
      input logic [LEN_W-1:0]  sa,
      input logic [DATA_W-1:0] lvl,
      input logic [DATA_W-1:0] ramp
   );
      logic [DATA_W-1:0] v;
      v = '0;
      case (m)
         STIM_STEP:    v = (i < sa) ? '0 : lvl;
         STIM_RAMP:    v = ramp;
         STIM_CONST:   v = lvl;
         STIM_IMPULSE: v = (i == sa) ? lvl : '0;
         default:      v = '0;
      endcase
      return v;
   endfunction

`ifdef STIM_LFSR_EN
   logic [31:0]       lfsr_state;
   logic              lfsr_load;
   logic              lfsr_adv;
   logic [DATA_W-1:0] noise_start;
   logic [DATA_W-1:0] noise_next;

   assign lfsr_load   = (state_q == ST_IDLE) && start;
   assign lfsr_adv    = (state_q == ST_RUN) && sample_ready;
   assign noise_start = LFSR_SEED[DATA_W-1:0];
   // Value the LFSR will hold after the step taken on this transfer
   assign noise_next  = DATA_W'(lfsr_step(lfsr_state));

   stim_lfsr #(
      .SEED    (LFSR_SEED)
   ) u_lfsr (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (lfsr_load),
      .step_i  (lfsr_adv),
      .state_o (lfsr_state)
   );
`endif

   // Next-state and registered-output computation for the burst sequencer
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      num_d     = num_q;
      step_at_d = step_at_q;
      level_d   = level_q;
      inc_d     = inc_q;
      acc_d     = acc_q;
      idx_d     = idx_q;
      out_d     = out_q;
      valid_d   = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               mode_d    = mode;
               num_d     = num_samples;
               step_at_d = step_at;
               level_d   = level;
               inc_d     = ramp_inc;
               acc_d     = '0;
               idx_d     = '0;
               if (num_samples == '0) begin
                  // Empty burst: straight to the done pulse, no sample
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  out_d   = '0;
               end else begin
                  state_d = ST_RUN;
                  valid_d = 1'b1;
                  busy_d  = 1'b1;
                  out_d   = sample_value(mode, '0, step_at, level, '0);
`ifdef STIM_LFSR_EN
                  if (mode == STIM_NOISE) out_d = noise_start;
`endif
               end
            end
         end

         ST_RUN: begin
            valid_d = 1'b1;
            busy_d  = 1'b1;
            if (sample_ready) begin
               if (idx_q == num_q - LEN_W'(1)) begin
                  state_d = ST_DONE;
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  out_d   = '0;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + LEN_W'(1);
                  acc_d = acc_q + inc_q;
                  out_d = sample_value(mode_q, idx_d, step_at_q, level_q, acc_d);
`ifdef STIM_LFSR_EN
                  if (mode_q == STIM_NOISE) out_d = noise_next;
`endif
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Latched burst parameters, counters and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q    <= STIM_ZERO;
         num_q     <= '0;
         step_at_q <= '0;
         level_q   <= '0;
         inc_q     <= '0;
         acc_q     <= '0;
         idx_q     <= '0;
         out_q     <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         mode_q    <= mode_d;
         num_q     <= num_d;
         step_at_q <= step_at_d;
         level_q   <= level_d;
         inc_q     <= inc_d;
         acc_q     <= acc_d;
         idx_q     <= idx_d;
         out_q     <= out_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign sample_out   = out_q;
   assign sample_valid = valid_q;
   assign sample_idx   = idx_q;
   assign busy         = busy_q;
   assign done         = done_q;

endmodule

// File: tb/tb_audio_stim_gen.sv
// Bench for audio_stim_gen: table of directed bursts, hand-written
// corner sequences (empty burst, mid-burst reset) and random bursts,
// all checked sample-by-sample against a reference model.
module tb_audio_stim_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  mode = 3'd0;
   logic [15:0] num_samples = 16'd0;
   logic [15:0] step_at = 16'd0;
   logic [23:0] level = 24'd0;
   logic [23:0] ramp_inc = 24'd0;
   logic [23:0] sample_out;
   logic        sample_valid;
   logic        sample_ready = 1'b1;
   logic [15:0] sample_idx;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   logic [31:0] noise_tab [0:4095];
   logic [23:0] cap  [0:4095];
   logic [23:0] cap2 [0:15];

   always #5 clk = ~clk;

   audio_stim_gen #(
      .DATA_W       (24),
      .LEN_W        (16),
      .LFSR_SEED    (32'hACE1_0001)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .mode         (mode),
      .num_samples  (num_samples),
      .step_at      (step_at),
      .level        (level),
      .ramp_inc     (ramp_inc),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .sample_idx   (sample_idx),
      .busy         (busy),
      .done         (done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference sample for index i of a burst with the given parameters
   function automatic logic [23:0] ref_sample(input int m, input int i, input int sa,
                                              input logic [23:0] lvl, input logic [23:0] inc);
      logic [63:0] prod;
      logic [31:0] nz;
      case (m)
         1: return (i < sa) ? 24'd0 : lvl;
         2: begin
            prod = 64'(i) * 64'(inc);
            return prod[23:0];
         end
         3: return lvl;
         4: begin
`ifdef STIM_LFSR_EN
            nz = noise_tab[i];
`else
            nz = 32'd0;
`endif
            return nz[23:0];
         end
         5: return (i == sa) ? lvl : 24'd0;
         default: return 24'd0;
      endcase
   endfunction

   // Drive one burst (entered just after a negedge). rmode: 0 ready high,
   // 1 ready toggling 1-0-1, 2 random ready. Inputs and start are scrambled
   // during the burst to show the latched copies are used.
   task automatic run_burst(input int m, input int n, input int sa, input logic [23:0] lvl,
                            input logic [23:0] inc, input int rmode, input string tag,
                            output int ncap, output int ncyc);
      logic        prev_stall;
      logic [23:0] prev_s;
      logic [15:0] prev_i;
      logic        rdy;
      bit          fin;
      mode = 3'(m); num_samples = 16'(n); step_at = 16'(sa);
      level = lvl; ramp_inc = inc; start = 1'b1; sample_ready = 1'b1;
      ncap = 0; ncyc = 0; prev_stall = 1'b0; fin = 1'b0;
      prev_s = '0; prev_i = '0;
      @(posedge clk); #1;
      start = 1'($urandom); mode = 3'($urandom); num_samples = 16'($urandom);
      step_at = 16'($urandom); level = 24'($urandom); ramp_inc = 24'($urandom);
      if (n == 0) begin
         @(negedge clk);
         check({tag, " empty done"}, 32'(done), 32'd1);
         check({tag, " empty valid"}, 32'(sample_valid), 32'd0);
         start = 1'b0;
      end else begin
         for (int c = 0; c < 20000 && !fin; c++) begin
            @(negedge clk);
            check({tag, " valid"}, 32'(sample_valid), 32'd1);
            check({tag, " busy"}, 32'(busy), 32'd1);
            check({tag, " idx"}, 32'(sample_idx), 32'(ncap));
            check({tag, " sample"}, 32'(sample_out), 32'(ref_sample(m, ncap, sa, lvl, inc)));
            if (prev_stall) begin
               check({tag, " hold sample"}, 32'(sample_out), 32'(prev_s));
               check({tag, " hold idx"}, 32'(sample_idx), 32'(prev_i));
            end
            case (rmode)
               0: rdy = 1'b1;
               1: rdy = (c % 2) == 0;
               default: rdy = ($urandom % 4) != 0;
            endcase
            sample_ready = rdy;
            start = 1'($urandom); mode = 3'($urandom); level = 24'($urandom);
            cap[ncap] = sample_out;
            prev_s = sample_out; prev_i = sample_idx; prev_stall = !rdy;
            ncyc++;
            if (rdy) begin
               ncap++;
               if (ncap == n) fin = 1'b1;
            end
         end
         check({tag, " burst completed"}, 32'(fin), 32'd1);
         @(negedge clk);
         check({tag, " done pulse"}, 32'(done), 32'd1);
         check({tag, " valid after end"}, 32'(sample_valid), 32'd0);
         check({tag, " busy after end"}, 32'(busy), 32'd0);
         start = 1'b1;   // presented in the DONE cycle: must be ignored
      end
      sample_ready = 1'b1;
      @(negedge clk);
      check({tag, " done single"}, 32'(done), 32'd0);
      check({tag, " idle valid"}, 32'(sample_valid), 32'd0);
      start = 1'b0;
      @(negedge clk);
      check({tag, " idle stays"}, 32'(sample_valid | done), 32'd0);
      $display("burst %s: mode=%0d n=%0d transfers=%0d cycles=%0d", tag, m, n, ncap, ncyc);
   endtask

   typedef struct {
      int          m;
      int          n;
      int          sa;
      logic [23:0] lvl;
      logic [23:0] inc;
      int          rmode;
      logic [23:0] exp_first;
      logic [23:0] exp_last;
      int          exp_cycles;
   } vec_t;

   initial begin
      vec_t        vt [0:6];
      int          ncap, ncyc;
      logic [31:0] s;
      logic [23:0] nz_first;
      logic [31:0] nz15;

      // Noise reference: plain polynomial stepping of a 32-bit register
      s = 32'hACE1_0001;
      for (int i = 0; i < 4096; i++) begin
         noise_tab[i] = s;
         if (s[0]) s = (s >> 1) ^ 32'h8020_0003;
         else      s = s >> 1;
      end
`ifdef STIM_LFSR_EN
      nz_first = 24'hE10001;
      nz15 = noise_tab[15];
`else
      nz_first = 24'd0;
      nz15 = 32'd0;
`endif

      vt[0] = '{1, 512, 80, 24'h400000, 24'd0, 0, 24'd0, 24'h400000, 512};
      vt[1] = '{2, 4096, 0, 24'd0, 24'd4096, 0, 24'd0, 24'hFFF000, 4096};
      vt[2] = '{3, 512, 0, 24'h100000, 24'd0, 1, 24'h100000, 24'h100000, 1023};
      vt[3] = '{5, 8, 3, 24'hFFFFFF, 24'd0, 0, 24'd0, 24'd0, 8};
      vt[4] = '{0, 5, 0, 24'h123456, 24'd7, 2, 24'd0, 24'd0, -1};
      vt[5] = '{6, 4, 0, 24'h000005, 24'd9, 0, 24'd0, 24'd0, 4};
      vt[6] = '{4, 16, 0, 24'd0, 24'd0, 0, nz_first, nz15[23:0], 16};

      // Reset state
      #2;
      check("reset sample_out", 32'(sample_out), 32'd0);
      check("reset valid", 32'(sample_valid), 32'd0);
      check("reset idx", 32'(sample_idx), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed table
      for (int v = 0; v < 7; v++) begin
         run_burst(vt[v].m, vt[v].n, vt[v].sa, vt[v].lvl, vt[v].inc, vt[v].rmode,
                   $sformatf("vec%0d", v), ncap, ncyc);
         check($sformatf("vec%0d transfers", v), 32'(ncap), 32'(vt[v].n));
         check($sformatf("vec%0d first", v), 32'(cap[0]), 32'(vt[v].exp_first));
         check($sformatf("vec%0d last", v), 32'(cap[vt[v].n-1]), 32'(vt[v].exp_last));
         if (vt[v].exp_cycles >= 0)
            check($sformatf("vec%0d cycles", v), 32'(ncyc), 32'(vt[v].exp_cycles));
         if (v == 1) check("ramp idx 2048", 32'(cap[2048]), 32'h800000);
      end

      // NOISE twice back to back: identical sequences
      run_burst(4, 16, 0, 24'd0, 24'd0, 2, "noise_a", ncap, ncyc);
      for (int i = 0; i < 16; i++) cap2[i] = cap[i];
      run_burst(4, 16, 0, 24'd0, 24'd0, 0, "noise_b", ncap, ncyc);
      for (int i = 0; i < 16; i++) check("noise repeat", 32'(cap[i]), 32'(cap2[i]));
      check("noise first", 32'(cap[0]), 32'(nz_first));

      // Empty burst
      run_burst(5, 0, 0, 24'hFFFFFF, 24'd0, 0, "empty", ncap, ncyc);

      // Reset in the middle of a 512-sample STEP burst
      mode = 3'd1; num_samples = 16'd512; step_at = 16'd80; level = 24'h400000;
      sample_ready = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 300 && !(sample_valid && sample_idx == 16'd100); c++) @(negedge clk);
      check("abort reached idx 100", 32'(sample_idx), 32'd100);
      rst_n = 1'b0;
      #1;
      check("abort sample_out", 32'(sample_out), 32'd0);
      check("abort valid", 32'(sample_valid), 32'd0);
      check("abort idx", 32'(sample_idx), 32'd0);
      check("abort busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("abort no done", 32'(done | sample_valid), 32'd0);
      end
      run_burst(1, 120, 80, 24'h400000, 24'd0, 0, "restart", ncap, ncyc);
      check("restart first", 32'(cap[0]), 32'd0);

      // Random bursts
      for (int r = 0; r < 25; r++) begin
         run_burst(int'($urandom_range(0, 7)), int'($urandom_range(1, 40)),
                   int'($urandom_range(0, 45)), 24'($urandom), 24'($urandom), 2,
                   $sformatf("rand%0d", r), ncap, ncyc);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/audio_stim_gen.md
# audio_stim_gen

Synthesizable, parametrised audio test-pattern generator that drives the FIR filter bank input with step, ramp, constant, noise and impulse sequences of programmable length. It replaces simulation-only stimulus loops with an on-chip BIST source usable on the board and in the bench. A valid/ready handshake paces it against the filter bank or a capture FIFO.

## Interface
- DATA_W, 24, sample width, two's complement; 2..32
- LEN_W, 16, width of sample counter and length/position fields
- LFSR_SEED, 32'hACE1_0001, nonzero noise seed
- clk  in  1  sample-domain clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request; sampled only in IDLE
- mode  in  3  0 ZERO, 1 STEP, 2 RAMP, 3 CONST, 4 NOISE, 5 IMPULSE, 6-7 reserved
- num_samples  in  LEN_W  burst length
- step_at  in  LEN_W  step/impulse sample index
- level  in  DATA_W  signed amplitude for STEP/CONST/IMPULSE
- ramp_inc  in  DATA_W  signed ramp increment per sample
- sample_out  out  DATA_W  signed sample
- sample_valid  out  1  sample_out is valid
- sample_ready  in  1  downstream accepts
- sample_idx  out  LEN_W  index of sample_out
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at burst end

## Operation
- FSM IDLE -> RUN -> DONE -> IDLE. On start in IDLE: latch mode, num_samples, step_at, level, ramp_inc; idx=0; ramp accumulator=0; LFSR=LFSR_SEED; go RUN.
- num_samples==0: start goes IDLE -> DONE directly; no sample issued.
- RUN: sample_valid=1. Transfer = valid & ready. On transfer: idx+1, ramp acc += ramp_inc, LFSR steps once; if idx==num_samples-1 go DONE (valid drops).
- Sample value at idx i: ZERO 0; STEP (i<step_at)?0:level; RAMP i*ramp_inc mod 2^DATA_W (wraps, no saturation); CONST level; NOISE LFSR[DATA_W-1:0]; IMPULSE (i==step_at)?level:0; reserved 0.
- LFSR: 32-bit Galois, right shift, taps mask 32'h8020_0003.
- Valid & !ready: sample_out, sample_idx held stable; no state advances.
- start while not IDLE ignored; input changes during a burst ignored (latched copies used).
- DONE: done=1 for exactly one cycle, then IDLE; start in DONE cycle ignored.
- rst_n low mid-burst: immediate abort to IDLE, no done pulse.

## Timing
- Reset values: sample_out 0, sample_valid 0, sample_idx 0, busy 0, done 0; LFSR=LFSR_SEED.
- All outputs registered. start at edge N -> valid, idx 0 and busy at N+1.
- Transfer at edge M -> next sample at M+1; sustained 1 sample/cycle with ready tied high.
- Last transfer at edge L -> valid=0, busy=0, done=1 at L+1; IDLE at L+2; earliest restart accepted at L+2.

## Configuration
- STIM_LFSR_EN defined: NOISE mode implemented as above.
- Undefined: LFSR register and logic removed; mode 4 behaves as ZERO (valid, idx, done sequence unchanged).

## Structure
- Package stim_pkg: mode encoding constants (STIM_ZERO..STIM_IMPULSE), FSM state encoding, LFSR tap mask constant.
- One sub-module: stim_lfsr (seed load, step enable, 32-bit state out), instantiated only under STIM_LFSR_EN.

## Test plan
- STEP, num_samples=512, step_at=80, level=24'h400000, ready=1 -> idx 0..79 output 0, 80..511 output 4194304, done one cycle after idx 511.
- RAMP, ramp_inc=4096, num_samples=4096 -> sample i = i*4096 wrapped to 24-bit signed; idx 2048 gives -8388608.
- CONST level=24'h100000 with ready toggling 1-0-1 per cycle -> 1048576 every transfer, output held stable while ready=0, 512 transfers in 1023 cycles.
- NOISE twice back-to-back, num_samples=16 -> identical sequences; first sample = LFSR_SEED[23:0]; with macro undefined all zero.
- IMPULSE step_at=3 level=-1 num_samples=8 -> 0,0,0,-1,0,0,0,0; num_samples=0 -> done at start+1, valid never high.
- rst_n low at idx 100 of a 512 burst -> outputs 0 immediately, no done; new start then produces idx 0 again.
